// File: rtl/m1rstctrl_pkg.sv
// m1rstctrl_pkg
//   Shared definitions for the reset-request controller.
//   - CSR register offsets (word index inside the bank)
//   - CAUSE bit positions and the power-up value of the cause register
//   - Unlock keys for soft reset and watchdog enable/kick
//   - Request-merge FSM state encoding
//   - Helper that applies write-one-to-clear and new events to the cause register
package m1rstctrl_pkg;

    // Register offsets, compared against csr_a[9:0]
    localparam logic [9:0] REG_CTRL   = 10'd0;
    localparam logic [9:0] REG_RELOAD = 10'd1;
    localparam logic [9:0] REG_WDT    = 10'd2;
    localparam logic [9:0] REG_CAUSE  = 10'd3;

    // CAUSE register bit positions
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_BTN  = 1;
    localparam int CAUSE_SOFT = 2;
    localparam int CAUSE_WDT  = 3;

    // Power-up content of the cause register: only POR set
    localparam logic [3:0] CAUSE_INIT = 4'b0001;

    // Unlock keys
    localparam logic [31:0] SOFT_KEY     = 32'h5AFE_0001;
    localparam logic [7:0]  WDT_EN_KEY   = 8'hA5;
    localparam logic [7:0]  WDT_KICK_KEY = 8'h5A;

    // Request merge: idle -> one-cycle pulse -> hold until sys_rst
    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_PULSE = 2'd1,
        REQ_HOLD  = 2'd2
    } req_state_t;

    // New events win over a clear issued in the same cycle.
    function automatic logic [3:0] cause_update(
        input logic [3:0] cur,
        input logic [3:0] clr,
        input logic [3:0] set
    );
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/m1rstctrl_debounce.sv
// m1rstctrl_debounce
//   Two-flop synchroniser for the raw (active-low) reset button followed by a
//   stable-count debouncer. The debounced state only changes after the
//   synchronised input has disagreed with it for debounce_cycles consecutive
//   clocks; any agreeing sample restarts the count.
//
//   The debounced state comes out of reset as "pressed". A button that is
//   idle at reset therefore produces a release_seen pulse once it has been
//   stable high long enough, while a button held through reset stays
//   "pressed" and never generates a fresh press edge until it is released.
//
// Parameters
//   debounce_cycles  consecutive stable cycles needed to change state (>= 1)
// Ports
//   clk           in   clock
//   srst          in   synchronous active-high reset
//   btn_n         in   raw button, active low, asynchronous to clk
//   pressed       out  debounced level, 1 = button held down
//   release_seen  out  one-cycle pulse after a debounced release
module m1rstctrl_debounce #(
    parameter logic [19:0] debounce_cycles = 20'd1000000
) (
    input  logic clk,
    input  logic srst,
    input  logic btn_n,
    output logic pressed,
    output logic release_seen
);

    logic [1:0]  sync_reg;
    logic [19:0] cnt_reg;
    logic        pressed_reg;
    logic        release_reg;
    logic        btn_low;

    // Synchroniser; resets to the idle (released) level.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], btn_n};
        end
    end

    assign btn_low = ~sync_reg[1];

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg     <= '0;
            pressed_reg <= 1'b1;
            release_reg <= 1'b0;
        end else begin
            release_reg <= 1'b0;
            if (btn_low == pressed_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == debounce_cycles - 20'd1) begin
                // This is the Nth consecutive disagreeing sample: accept it.
                cnt_reg     <= '0;
                pressed_reg <= btn_low;
                release_reg <= ~btn_low;
            end else begin
                cnt_reg <= cnt_reg + 20'd1;
            end
        end
    end

    assign pressed      = pressed_reg;
    assign release_seen = release_reg;

endmodule

// File: rtl/m1rstctrl.sv
// m1rstctrl
//   Reset-request controller driving the CRG trigger_reset input. Merges the
//   debounced board button, a keyed CSR software reset and the watchdog into a
//   single one-cycle trigger pulse, and keeps a sticky reset-cause register
//   that survives sys_rst (power-up value: POR only).
//
//   Build option: define M1RSTCTRL_WDT_EN to include the watchdog (RELOAD and
//   WDT registers, wdt_running, CAUSE.WDT). Without it those registers read 0,
//   ignore writes and no counter logic is built.
//
// Parameters
//   csr_addr         CSR bank select, compared against csr_a[13:10]
//   debounce_cycles  stable-low cycles needed to accept a button press
//   wdt_width        watchdog counter/reload width (1..32)
// Ports
//   sys_clk        in   system clock
//   sys_rst        in   synchronous active-high reset
//   btn_reset_n    in   raw reset button, active low, asynchronous
//   csr_a          in   CSR address (bank in [13:10], register in [9:0])
//   csr_we         in   CSR write strobe
//   csr_di         in   CSR write data
//   csr_do         out  CSR read data, registered, 0 when bank not selected
//   trigger_reset  out  one-cycle reset request to the CRG
//   wdt_running    out  watchdog enabled and counting
//
// Register map
//   0 CTRL    W: SOFT_KEY requests a soft reset, R: 0
//   1 RELOAD  RW: watchdog reload value
//   2 WDT     W: bit8 + WDT_EN_KEY enables/loads, WDT_KICK_KEY reloads; R: running
//   3 CAUSE   R: {WDT, SOFT, BTN, POR}, write-one-to-clear
module m1rstctrl #(
    parameter logic [3:0]  csr_addr        = 4'h0,
    parameter logic [19:0] debounce_cycles = 20'd1000000,
    parameter int          wdt_width       = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        btn_reset_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        trigger_reset,
    output logic        wdt_running
);

    import m1rstctrl_pkg::*;

    // ------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------
    logic       csr_sel;
    logic [9:0] reg_off;
    logic       csr_wr;

    assign csr_sel = (csr_a[13:10] == csr_addr);
    assign reg_off = csr_a[9:0];
    assign csr_wr  = csr_we && csr_sel;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    logic pressed;
    logic release_seen;
    logic pressed_d_reg;
    logic armed_reg;
    logic btn_req;

    m1rstctrl_debounce #(
        .debounce_cycles(debounce_cycles)
    ) u_debounce (
        .clk          (sys_clk),
        .srst         (sys_rst),
        .btn_n        (btn_reset_n),
        .pressed      (pressed),
        .release_seen (release_seen)
    );

    // Only a fresh press (rising debounced level) after a debounced release
    // counts. pressed_d_reg resets to 1 to match the debouncer reset state so
    // reset itself never looks like a press.
    assign btn_req = pressed && !pressed_d_reg && armed_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pressed_d_reg <= 1'b1;
            armed_reg     <= 1'b0;
        end else begin
            pressed_d_reg <= pressed;
            if (btn_req) begin
                armed_reg <= 1'b0;
            end else if (release_seen) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Software reset: registered so the request appears the cycle after the
    // write and the pulse the cycle after that.
    // ------------------------------------------------------------------
    logic soft_req_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            soft_req_reg <= 1'b0;
        end else begin
            soft_req_reg <= csr_wr && (reg_off == REG_CTRL) && (csr_di == SOFT_KEY);
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic [wdt_width-1:0] reload_val;
    logic                 wdt_running_val;
    logic                 wdt_req;

`ifdef M1RSTCTRL_WDT_EN
    logic [wdt_width-1:0] reload_reg;
    logic [wdt_width-1:0] wdt_cnt_reg;
    logic                 running_reg;
    logic                 wdt_load;
    logic                 wdt_kick;

    assign wdt_load = csr_wr && (reg_off == REG_WDT) && csr_di[8]
                      && (csr_di[7:0] == WDT_EN_KEY);
    // A kick only means something once the watchdog is running.
    assign wdt_kick = csr_wr && (reg_off == REG_WDT) && running_reg
                      && (csr_di[7:0] == WDT_KICK_KEY);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            reload_reg  <= '0;
            wdt_cnt_reg <= '0;
            running_reg <= 1'b0;
        end else begin
            if (csr_wr && (reg_off == REG_RELOAD)) begin
                reload_reg <= csr_di[wdt_width-1:0];
            end
            if (wdt_load) begin
                // Enabling is one-way; only sys_rst clears running_reg.
                running_reg <= 1'b1;
                wdt_cnt_reg <= reload_reg;
            end else if (wdt_kick) begin
                wdt_cnt_reg <= reload_reg;
            end else if (running_reg && (wdt_cnt_reg != '0)) begin
                // Saturates at 0 so the request stays asserted after expiry.
                wdt_cnt_reg <= wdt_cnt_reg - wdt_width'(1);
            end
        end
    end

    assign reload_val      = reload_reg;
    assign wdt_running_val = running_reg;
    // A kick arriving in the expiry cycle rescues the system.
    assign wdt_req         = running_reg && (wdt_cnt_reg == '0) && !wdt_kick;
`else
    assign reload_val      = '0;
    assign wdt_running_val = 1'b0;
    assign wdt_req         = 1'b0;
`endif

    assign wdt_running = wdt_running_val;

    // ------------------------------------------------------------------
    // Request merge and hold-off FSM
    // ------------------------------------------------------------------
    logic [3:0] req_vec;
    logic       any_req;
    logic [3:0] cause_set;
    req_state_t state_reg;
    req_state_t state_next;

    always_comb begin
        req_vec             = '0;
        req_vec[CAUSE_BTN]  = btn_req;
        req_vec[CAUSE_SOFT] = soft_req_reg;
        req_vec[CAUSE_WDT]  = wdt_req;
    end

    assign any_req = |req_vec;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= REQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REQ_IDLE:  if (any_req) state_next = REQ_PULSE;
            REQ_PULSE: state_next = REQ_HOLD;
            // Leave only through sys_rst from the CRG.
            REQ_HOLD:  state_next = REQ_HOLD;
            default:   state_next = REQ_IDLE;
        endcase
    end

    always_comb begin
        trigger_reset = (state_reg == REQ_PULSE);
        // Cause bits are latched on the same edge that starts the pulse, so
        // they appear together with trigger_reset.
        cause_set = ((state_reg == REQ_IDLE) && any_req) ? req_vec : 4'b0000;
    end

    // ------------------------------------------------------------------
    // Cause register: initialised at configuration time, untouched by
    // sys_rst so software can read why the system came back up.
    // ------------------------------------------------------------------
    logic [3:0] cause_reg = CAUSE_INIT;
    logic [3:0] cause_clr;

    assign cause_clr = (csr_wr && (reg_off == REG_CAUSE)) ? csr_di[3:0] : 4'b0000;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cause_reg <= cause_update(cause_reg, cause_clr, cause_set);
        end
    end

    // ------------------------------------------------------------------
    // CSR read path
    // ------------------------------------------------------------------
    logic [31:0] rd_data;
    logic [31:0] csr_do_reg;

    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_RELOAD: rd_data = 32'(reload_val);
            REG_WDT:    rd_data = {31'b0, wdt_running_val};
            REG_CAUSE:  rd_data = {28'b0, cause_reg};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            csr_do_reg <= '0;
        end else begin
            csr_do_reg <= csr_sel ? rd_data : 32'h0;
        end
    end

    assign csr_do = csr_do_reg;

endmodule

// File: tb/tb_m1rstctrl.sv
// tb_m1rstctrl
//   Directed bench for m1rstctrl with debounce_cycles = 16. Covers reset state,
//   button glitch rejection and accepted press, keyed soft reset timing and
//   hold-off, watchdog kick/expiry (or its absence without M1RSTCTRL_WDT_EN),
//   simultaneous requests, cause persistence across sys_rst with W1C, and a
//   button held through reset.
module tb_m1rstctrl;

    localparam logic [13:0] A_CTRL   = 14'h0000;
    localparam logic [13:0] A_RELOAD = 14'h0001;
    localparam logic [13:0] A_WDT    = 14'h0002;
    localparam logic [13:0] A_CAUSE  = 14'h0003;
    localparam logic [13:0] A_OTHER  = 14'h0403;  // bank 1, not selected

    logic        sys_clk;
    logic        sys_rst;
    logic        btn_reset_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        trigger_reset;
    logic        wdt_running;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    m1rstctrl #(
        .csr_addr        (4'h0),
        .debounce_cycles (20'd16),
        .wdt_width       (32)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .btn_reset_n   (btn_reset_n),
        .csr_a         (csr_a),
        .csr_we        (csr_we),
        .csr_di        (csr_di),
        .csr_do        (csr_do),
        .trigger_reset (trigger_reset),
        .wdt_running   (wdt_running)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Every high sample at the falling edge is one pulse cycle.
    always @(negedge sys_clk) begin
        if (trigger_reset === 1'b1) pulse_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic csr_write(input logic [13:0] addr, input logic [31:0] data);
        csr_a  = addr;
        csr_di = data;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
        $display("csr wr a=%h d=%h", addr, data);
    endtask

    task automatic csr_read(input logic [13:0] addr, output logic [31:0] data);
        csr_a  = addr;
        csr_we = 1'b0;
        tick();
        data = csr_do;
        $display("csr rd a=%h d=%h", addr, data);
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        csr_we  = 1'b0;
        ticks(n);
        sys_rst = 1'b0;
        $display("reset %0d cycles", n);
    endtask

    logic [31:0] rd;
    int          p0;
    int          lat;
    bit          found;

    initial begin
        sys_rst     = 1'b1;
        btn_reset_n = 1'b1;
        csr_a       = A_CTRL;
        csr_we      = 1'b0;
        csr_di      = '0;

        // ---------------- reset state ----------------
        do_reset(4);
        check_val("rst_trigger", {31'b0, trigger_reset}, 32'd0);
        check_val("rst_wdt_running", {31'b0, wdt_running}, 32'd0);
        check_val("rst_csr_do", csr_do, 32'd0);
        csr_read(A_CAUSE, rd);
        check_val("cause_por", rd, 32'h1);
        csr_read(A_OTHER, rd);
        check_val("bank_unselected", rd, 32'h0);

        // ---------------- 1: button ----------------
        ticks(40);                    // idle high long enough to arm
        p0 = pulse_cnt;
        btn_reset_n = 1'b0;
        ticks(10);                    // shorter than debounce: glitch
        btn_reset_n = 1'b1;
        ticks(30);
        check_val("btn_glitch_pulses", pulse_cnt - p0, 0);
        p0 = pulse_cnt;
        btn_reset_n = 1'b0;
        ticks(40);
        check_val("btn_press_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("btn_cause", rd, 32'h3);
        btn_reset_n = 1'b1;
        ticks(20);
        do_reset(3);

        // ---------------- 2: soft reset ----------------
        // Key write in cycle N, W1C of SOFT in N+1 coincides with the set edge:
        // the bit must stay set. Pulse visible in N+2 only.
        p0 = pulse_cnt;
        csr_write(A_CTRL, 32'h5AFE_0001);
        check_val("soft_n1", {31'b0, trigger_reset}, 32'd0);
        csr_write(A_CAUSE, 32'h4);
        check_val("soft_n2", {31'b0, trigger_reset}, 32'd1);
        tick();
        check_val("soft_n3", {31'b0, trigger_reset}, 32'd0);
        ticks(5);
        check_val("soft_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("soft_cause_w1c_race", rd, 32'h7);
        p0 = pulse_cnt;
        csr_write(A_CTRL, 32'h5AFE_0001);
        ticks(10);
        check_val("soft_holdoff", pulse_cnt - p0, 0);
        do_reset(3);
        p0 = pulse_cnt;
        csr_write(A_CTRL, 32'h5AFE_0002);
        ticks(10);
        check_val("soft_badkey", pulse_cnt - p0, 0);
        csr_read(A_CTRL, rd);
        check_val("ctrl_reads_zero", rd, 32'h0);

        // ---------------- 3: watchdog ----------------
`ifdef M1RSTCTRL_WDT_EN
        csr_write(A_RELOAD, 32'd100);
        csr_read(A_RELOAD, rd);
        check_val("reload_rb", rd, 32'd100);
        csr_write(A_WDT, 32'h1A5);
        check_val("wdt_running_on", {31'b0, wdt_running}, 32'd1);
        csr_read(A_WDT, rd);
        check_val("wdt_reg_rb", rd, 32'h1);
        p0 = pulse_cnt;
        for (int k = 0; k < 20; k++) begin
            csr_write(A_WDT, 32'h5A);
            ticks(49);
        end
        check_val("wdt_kicked_pulses", pulse_cnt - p0, 0);
        // After a kick the counter holds 100 and reaches 0 100 cycles later;
        // a kick landing exactly in that cycle must win.
        csr_write(A_WDT, 32'h5A);
        ticks(100);
        csr_write(A_WDT, 32'h5A);
        check_val("wdt_kick_at_zero", pulse_cnt - p0, 0);
        // Counter=0 at cycle 101 after the kick edge -> request -> pulse seen
        // 101 sampling ticks after the write returns.
        found = 1'b0;
        lat   = 0;
        for (int j = 1; j <= 200 && !found; j++) begin
            tick();
            if (trigger_reset === 1'b1) begin
                found = 1'b1;
                lat   = j;
            end
        end
        check_val("wdt_latency", lat, 101);
        ticks(5);
        check_val("wdt_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("wdt_cause", rd, 32'hF);
`else
        csr_write(A_RELOAD, 32'd100);
        csr_read(A_RELOAD, rd);
        check_val("reload_absent", rd, 32'd0);
        csr_write(A_WDT, 32'h1A5);
        check_val("wdt_running_absent", {31'b0, wdt_running}, 32'd0);
        csr_read(A_WDT, rd);
        check_val("wdt_reg_absent", rd, 32'h0);
        p0 = pulse_cnt;
        ticks(150);
        check_val("wdt_absent_pulses", pulse_cnt - p0, 0);
`endif

        // ---------------- 4: simultaneous ----------------
        do_reset(3);
        csr_write(A_CAUSE, 32'hF);
        csr_read(A_CAUSE, rd);
        check_val("cause_cleared", rd, 32'h0);
        p0 = pulse_cnt;
`ifdef M1RSTCTRL_WDT_EN
        csr_write(A_RELOAD, 32'd20);
        csr_write(A_WDT, 32'h1A5);    // counter=20 after this edge
        ticks(19);                    // counter=1 during the next write cycle
        csr_write(A_CTRL, 32'h5AFE_0001);
        tick();
        check_val("simul_trigger", {31'b0, trigger_reset}, 32'd1);
        ticks(10);
        check_val("simul_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("simul_cause", rd, 32'hC);
`else
        csr_write(A_CTRL, 32'h5AFE_0001);
        ticks(10);
        check_val("soft2_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("soft2_cause", rd, 32'h4);
`endif

        // ---------------- 5: persistence across sys_rst ----------------
        csr_a   = A_CAUSE;
        sys_rst = 1'b1;
        ticks(5);
        check_val("rst5_csr_do", csr_do, 32'h0);
        check_val("rst5_wdt_running", {31'b0, wdt_running}, 32'd0);
        check_val("rst5_trigger", {31'b0, trigger_reset}, 32'd0);
        sys_rst = 1'b0;
        csr_read(A_CAUSE, rd);
`ifdef M1RSTCTRL_WDT_EN
        check_val("cause_persist", rd, 32'hC);
`else
        check_val("cause_persist", rd, 32'h4);
`endif
        csr_write(A_CAUSE, 32'hF);
        csr_read(A_CAUSE, rd);
        check_val("cause_w1c_all", rd, 32'h0);

        // ---------------- 6: button held through reset ----------------
        btn_reset_n = 1'b0;
        do_reset(5);
        p0 = pulse_cnt;
        ticks(60);
        check_val("held_no_pulse", pulse_cnt - p0, 0);
        btn_reset_n = 1'b1;
        ticks(40);
        check_val("held_release_no_pulse", pulse_cnt - p0, 0);
        btn_reset_n = 1'b0;
        ticks(40);
        check_val("held_repress_pulses", pulse_cnt - p0, 1);
        csr_read(A_CAUSE, rd);
        check_val("held_cause", rd, 32'h2);
        btn_reset_n = 1'b1;
        ticks(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
